// File: rtl/rr_arb4x8.sv
// rr_arb4x8 -- four-requester round-robin arbiter feeding one 8-bit
// registered output slot with valid/ready handshake.
//
// Ports
//   CLK      in   1  clock, rising edge
//   RESET    in   1  asynchronous active-high reset
//   I0..I3   in   8  requester data words
//   V        in   4  per-requester valid (V[k] qualifies Ik)
//   R        out  4  per-requester accept strobe (combinational, one-hot)
//   O        out  8  registered output word
//   O_VALID  out  1  O holds an undelivered word
//   O_READY  in   1  consumer takes O this cycle when O_VALID=1
//   O_SRC    out  2  index of the requester whose word sits in O
//
// Priority: PTR holds the last accepted index; the search starts at PTR+1
// and wraps modulo 4, so a continuously valid requester waits at most three
// other accepts. A word is accepted whenever the slot is free (empty or
// draining this cycle), which gives one transfer per cycle at full rate.
module rr_arb4x8 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [7:0] I3,
  input  logic [3:0] V,
  output logic [3:0] R,
  output logic [7:0] O,
  output logic       O_VALID,
  input  logic       O_READY,
  output logic [1:0] O_SRC
);

  logic [1:0] ptr;
  logic [1:0] g;
  logic       any;
  logic       free;
  logic       acc;
  logic [7:0] sel;

  // Rotating first-one search starting just after ptr. The i=4 step lands
  // back on ptr itself, so the last accepted requester has lowest priority.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned -- otherwise synthesis infers a latch.
    idx = '0;
    g   = ptr;
    any = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!any && V[idx]) begin
        g   = idx;
        any = 1'b1;
      end
    end
  end

  assign free = !O_VALID || O_READY;
  // Gating with RESET keeps R silent while reset is held, regardless of V.
  assign acc  = any && free && !RESET;
  assign R    = acc ? (4'b0001 << g) : 4'b0000;

  // The only data path from the requesters to O: a 4:1 mux steered by g.
  always_comb begin
    unique case (g)
      2'd0:    sel = I0;
      2'd1:    sel = I1;
      2'd2:    sel = I2;
      default: sel = I3;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      O       <= 8'h00;
      O_SRC   <= 2'd0;
      O_VALID <= 1'b0;
      ptr     <= 2'd3;   // first grant after reset goes to requester 0
    end else if (acc) begin
      // Covers both a fill of an empty slot and a same-edge drain+replace.
      O       <= sel;
      O_SRC   <= g;
      O_VALID <= 1'b1;
      ptr     <= g;
    end else if (O_READY) begin
      // Drain with nothing to replace it; data and source hold.
      O_VALID <= 1'b0;
    end
  end

endmodule

// File: doc/rr_arb4x8.md
RR_ARB4X8 -- requirements
Module: rr_arb4x8

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and requester count at 4.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 I0, I1, I2, I3  input  8 each  requester data words.
REQ-005 V  input  4  per-requester valid; V[k] qualifies Ik.
REQ-006 R  output  4  per-requester accept strobe; R[k]=1 means Ik is taken this cycle.
REQ-007 O  output  8  registered output data.
REQ-008 O_VALID  output  1  O holds an undelivered word.
REQ-009 O_READY  input  1  downstream consumer accepts O this cycle when O_VALID=1.
REQ-010 O_SRC  output  2  index of the requester whose word is in O.

Function
REQ-011 The block SHALL hold a 2-bit priority pointer PTR, equal to the index of the last accepted requester.
REQ-012 Grant search order SHALL be PTR+1, PTR+2, PTR+3, PTR (mod 4); G is the first index k in that order with V[k]=1.
REQ-013 Output slot free (FREE) SHALL be defined as O_VALID=0 or O_READY=1.
REQ-014 Accept (ACC) SHALL be defined as (V != 0) and FREE.
REQ-015 R SHALL be combinational, one-hot at index G when ACC=1, and all zero otherwise.
REQ-016 R[k] SHALL never be 1 while V[k]=0.
REQ-017 Data selection SHALL be a 4:1 8-bit mux steered by G; no other path from Ik to O is permitted.
REQ-018 On a clock edge with ACC=1, the block SHALL set O to IG, O_SRC to G, O_VALID to 1 and PTR to G.
REQ-019 On a clock edge with ACC=0, O_VALID=1 and O_READY=1, the block SHALL clear O_VALID; O and O_SRC SHALL hold.
REQ-020 With O_VALID=1 and O_READY=0, O, O_SRC and PTR SHALL hold unchanged regardless of V or I.
REQ-021 Simultaneous drain and accept (O_VALID=1, O_READY=1, V!=0) SHALL replace the word in the same edge with O_VALID staying 1, giving one transfer per cycle.
REQ-022 Latency from the ACC cycle to O_VALID=1 with the new word SHALL be exactly 1 cycle.
REQ-023 O_READY while O_VALID=0 SHALL have no effect beyond contributing to FREE.
REQ-024 Requesters MAY drop V without being accepted; no request state is retained for them.
REQ-025 A requester holding V=1 continuously SHALL be accepted within 4 consecutive ACC events.
REQ-026 PTR wrap-around SHALL be modulo 4; for example, PTR=3 with all V=1 grants 0.

Reset
REQ-027 While RESET=1: O_VALID=0, O=8'h00, O_SRC=0, PTR=3 and R=4'b0000, independent of CLK.
REQ-028 Reset asserted mid-transfer SHALL discard the held word immediately; no R pulse SHALL occur during reset.
REQ-029 After RESET deasserts, the first accept with all V=1 SHALL grant requester 0.

Verification
REQ-030 Reset, then V=4'b1111, I0..I3 = 8'h10, 8'h21, 8'h32, 8'h43, O_READY=1 for 8 cycles -> R cycles 0001, 0010, 0100, 1000 and repeats; O sequence 10, 21, 32, 43, 10, ... one cycle later; O_VALID stays 1.
REQ-031 V=4'b0100, I2=8'hA5, O_READY=0 for 5 cycles -> a single R=0100 pulse; O=A5, O_SRC=2 and O_VALID=1 held; R=0 thereafter; raising O_READY for 1 cycle with V=0 -> O_VALID=0 next cycle.
REQ-032 Backpressure with O_VALID=1, O_READY=0 and V=4'b1111 -> R=0, O stable; assert O_READY=1 for one cycle -> exactly one R pulse at PTR+1 and O updated in that same edge.
REQ-033 PTR=1 with V=4'b0011 -> grant 0 (wrap past 2 and 3); next ACC grants 1.
REQ-034 Assert RESET asynchronously between edges while O_VALID=1 -> O_VALID, O and O_SRC go to 0 before the next edge; after release, V=4'b1010 -> grant 1.
REQ-035 Random V and O_READY for 10k cycles -> scoreboard shows every R pulse produces exactly one O word in order, no word is lost or duplicated, and the REQ-025 fairness bound holds.
